alu_seq_param: RTL
==================

Name: alu_seq_param

Overview:
- Parametrised, multi-cycle successor to the 8-bit start/done ALU.
- Performs ADD/SUB in one execute cycle, unsigned MUL via shift-add, and unsigned DIV via restoring division (WIDTH iterations each).
- Adds a double-width result path (product high half / remainder), status flags and divide-by-zero detection.
- Sits between the operand registers and the result bus; the controller drives it with start and waits for done.

Parameters:
- WIDTH, 8, operand and result word width in bits (>=2).
- CNT_W, $clog2(WIDTH+1), iteration counter width (derived; do not override).

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- start  input  1  operation request; sampled only in IDLE or DONE.
- opcode  input  2  00 ADD, 01 SUB, 10 MUL, 11 DIV; latched with start.
- inbus_a  input  WIDTH  operand A / dividend; latched with start.
- inbus_b  input  WIDTH  operand B / divisor; latched with start.
- outbus  output  WIDTH  sum, difference, product low half, or quotient.
- outbus_hi  output  WIDTH  product high half (MUL), remainder (DIV), 0 for ADD/SUB.
- done  output  1  one-cycle pulse; results valid from this cycle until the next accepted start.
- busy  output  1  high while in EXEC_AS or ITER.
- carry  output  1  ADD: carry-out; SUB: borrow (A<B); MUL: outbus_hi!=0; DIV: 0.
- overflow  output  1  ADD/SUB: two's-complement signed overflow; MUL/DIV: 0.
- zero  output  1  outbus==0.
- div_zero  output  1  DIV with inbus_b==0.

Behaviour:
- Reset (reset=0, asynchronous): state IDLE, every output and internal register 0. Reset during any state aborts the operation; no done is produced.
- FSM states: IDLE, EXEC_AS, ITER, DONE.
- IDLE/DONE with start=1 at edge N:
  - latch opcode and operands; clear iteration counter and all flags.
  - opcode 0x → EXEC_AS; 1x → ITER.
- IDLE/DONE with start=0: DONE → IDLE; IDLE holds.
- start while busy is ignored; operands and opcode must not be re-sampled.
- EXEC_AS, edge N+1:
  - register outbus = A±B mod 2^WIDTH, outbus_hi=0, carry, overflow and zero.
  - → DONE.
- ITER, MUL:
  - {hi,lo} shift-add, one multiplier bit per cycle, LSB first.
  - Edges N+1..N+WIDTH; the last edge writes the final product and → DONE.
- ITER, DIV with B!=0:
  - restoring division, one quotient bit per cycle, MSB first.
  - Edges N+1..N+WIDTH; the last edge → DONE.
- ITER, DIV with B==0:
  - at edge N+1: outbus = all ones, outbus_hi = A, div_zero=1, zero=0, → DONE.
  - no iterations are performed.
- DONE: done=1 for exactly this one cycle.
- Outputs hold their values until the next accepted start. They are not cleared on leaving DONE.
- Latency, start edge to done-high cycle:
  - ADD/SUB: 1 edge.
  - MUL and DIV (B!=0): WIDTH edges.
  - DIV by zero: 1 edge.
- Back-to-back: start=1 during the DONE cycle is accepted at that edge, so there is no idle gap.
- Arithmetic is unsigned except the overflow flag. All results wrap modulo 2^WIDTH per half.

Decomposition:
- Package alu_seq_pkg:
  - opcode localparams OP_ADD/OP_SUB/OP_MUL/OP_DIV.
  - FSM state encodings S_IDLE/S_EXEC_AS/S_ITER/S_DONE.
- Sub-module alu_seq_iter:
  - holds the shared {hi,lo} shift register, the WIDTH+1-bit adder/subtractor and the iteration counter for MUL/DIV.
  - the top holds the FSM, flags, and the ADD/SUB path.

Test Plan (WIDTH=8 unless stated):
- ADD/SUB:
  - ADD 15+10 → outbus=25, carry=0, overflow=0, done 1 cycle after start edge.
  - ADD 100+100 → outbus=200, overflow=1, carry=0.
  - SUB 20−8 → 12, carry=0.
  - SUB 8−20 → 244, carry=1.
- MUL:
  - 5×6 → outbus=30, outbus_hi=0, done exactly 8 edges after start.
  - 200×200 → outbus=64, outbus_hi=156, carry=1.
- DIV:
  - 25/5 → outbus=5, outbus_hi=0.
  - 100/7 → outbus=14, outbus_hi=2, done after 8 edges.
  - 25/0 → outbus=255, outbus_hi=25, div_zero=1, done after 1 edge.
- Robustness:
  - start pulsed mid-MUL with new operands → ignored; original product returned.
  - reset asserted mid-DIV → all outputs 0 immediately, no done.
  - back-to-back ADD then SUB with start held in the DONE cycle → both results in consecutive done pulses.
- WIDTH=16 regression: 65535×65535 → outbus=1, outbus_hi=65534. 1000/3 → 333, remainder 1, latency 16 edges.

Source files
------------

// File: rtl/alu_seq_pkg.sv
// Shared opcode and FSM-state encodings for the sequential ALU.
package alu_seq_pkg;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_MUL = 2'b10;
  localparam logic [1:0] OP_DIV = 2'b11;

  localparam logic [1:0] S_IDLE    = 2'b00;
  localparam logic [1:0] S_EXEC_AS = 2'b01;
  localparam logic [1:0] S_ITER    = 2'b10;
  localparam logic [1:0] S_DONE    = 2'b11;

endpackage

// File: rtl/alu_seq_param_if.sv
// Controller-side bus of the sequential ALU, plus the FSM state for observation.
interface alu_seq_param_if #(parameter int WIDTH = 8);
  // Handshake: start is sampled only in IDLE/DONE, where it latches opcode and
  // operands; done pulses for one cycle and results stay valid until the next
  // accepted start. start while busy is ignored.
  logic             start;
  logic [1:0]       opcode;
  logic [WIDTH-1:0] inbus_a;
  logic [WIDTH-1:0] inbus_b;
  logic [WIDTH-1:0] outbus;
  logic [WIDTH-1:0] outbus_hi;
  logic             done;
  logic             busy;
  logic             carry;
  logic             overflow;
  logic             zero;
  logic             div_zero;
  logic [1:0]       fsm_state;

  modport master (
    output start, opcode, inbus_a, inbus_b,
    input  outbus, outbus_hi, done, busy, carry, overflow, zero, div_zero, fsm_state
  );

  modport slave (
    input  start, opcode, inbus_a, inbus_b,
    output outbus, outbus_hi, done, busy, carry, overflow, zero, div_zero, fsm_state
  );
endinterface

// File: rtl/alu_seq_iter.sv
// Iterative datapath: shared {hi,lo} shift register and adder for shift-add
// multiply (LSB first) and restoring divide (MSB first).
module alu_seq_iter
  import alu_seq_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] a_in,
  input  logic             run,
  input  logic             is_div,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] hi_nxt,
  output logic [WIDTH-1:0] lo_nxt,
  output logic             last
);

  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH:0]   add_a;
  logic [WIDTH+1:0] add_res;

  // Divide subtracts B from the partial remainder shifted left by one dividend
  // bit; the extra top bit of add_res is the borrow deciding restore or keep.
  always_comb begin
    add_a   = is_div ? {hi, lo[WIDTH-1]} : {1'b0, hi};
    add_res = is_div ? ({1'b0, add_a} - {2'b00, b}) : ({1'b0, add_a} + {2'b00, b});
    hi_nxt  = hi;
    lo_nxt  = lo;
    if (is_div) begin
      if (add_res[WIDTH+1]) begin
        hi_nxt = add_a[WIDTH-1:0];
        lo_nxt = {lo[WIDTH-2:0], 1'b0};
      end else begin
        hi_nxt = add_res[WIDTH-1:0];
        lo_nxt = {lo[WIDTH-2:0], 1'b1};
      end
    end else if (lo[0]) begin
      {hi_nxt, lo_nxt} = {add_res[WIDTH:0], lo[WIDTH-1:1]};
    end else begin
      {hi_nxt, lo_nxt} = {1'b0, hi, lo[WIDTH-1:1]};
    end
  end

  assign last = run && (cnt == CNT_W'(WIDTH - 1));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hi  <= '0;
      lo  <= '0;
      cnt <= '0;
    end else if (load) begin
      hi  <= '0;
      lo  <= a_in;
      cnt <= '0;
    end else if (run) begin
      hi  <= hi_nxt;
      lo  <= lo_nxt;
      cnt <= cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/alu_seq_param.sv
// Multi-cycle ALU: one-cycle ADD/SUB, iterative MUL/DIV, start/done protocol.
module alu_seq_param
  import alu_seq_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  alu_seq_param_if.slave   bus
);

  logic [1:0]       state;
  logic [1:0]       op_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] out_lo;
  logic [WIDTH-1:0] out_hi;
  logic             carry_q, overflow_q, zero_q, div_zero_q;
  logic             accept;
  logic [WIDTH:0]   as_res;
  logic             as_ovf;
  logic [WIDTH-1:0] hi_nxt, lo_nxt;
  logic             iter_last;

  assign accept = ((state == S_IDLE) || (state == S_DONE)) && bus.start;

  always_comb begin
    as_res = (op_q == OP_SUB) ? ({1'b0, a_q} - {1'b0, b_q}) : ({1'b0, a_q} + {1'b0, b_q});
    if (op_q == OP_SUB)
      as_ovf = (a_q[WIDTH-1] != b_q[WIDTH-1]) && (as_res[WIDTH-1] != a_q[WIDTH-1]);
    else
      as_ovf = (a_q[WIDTH-1] == b_q[WIDTH-1]) && (as_res[WIDTH-1] != a_q[WIDTH-1]);
  end

  alu_seq_iter #(.WIDTH(WIDTH), .CNT_W(CNT_W)) u_iter (
    .clk    (clk),
    .reset  (reset),
    .load   (accept && bus.opcode[1]),
    .a_in   (bus.inbus_a),
    .run    (state == S_ITER),
    .is_div (op_q == OP_DIV),
    .b      (b_q),
    .hi_nxt (hi_nxt),
    .lo_nxt (lo_nxt),
    .last   (iter_last)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= S_IDLE;
      op_q       <= '0;
      a_q        <= '0;
      b_q        <= '0;
      out_lo     <= '0;
      out_hi     <= '0;
      carry_q    <= 1'b0;
      overflow_q <= 1'b0;
      zero_q     <= 1'b0;
      div_zero_q <= 1'b0;
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          if (bus.start) begin
            op_q       <= bus.opcode;
            a_q        <= bus.inbus_a;
            b_q        <= bus.inbus_b;
            carry_q    <= 1'b0;
            overflow_q <= 1'b0;
            zero_q     <= 1'b0;
            div_zero_q <= 1'b0;
            state      <= bus.opcode[1] ? S_ITER : S_EXEC_AS;
          end else begin
            state <= S_IDLE;
          end
        end
        S_EXEC_AS: begin
          out_lo     <= as_res[WIDTH-1:0];
          out_hi     <= '0;
          carry_q    <= as_res[WIDTH];
          overflow_q <= as_ovf;
          zero_q     <= (as_res[WIDTH-1:0] == '0);
          state      <= S_DONE;
        end
        S_ITER: begin
          // Divide by zero short-circuits: saturated quotient, dividend as remainder.
          if ((op_q == OP_DIV) && (b_q == '0)) begin
            out_lo     <= '1;
            out_hi     <= a_q;
            div_zero_q <= 1'b1;
            zero_q     <= 1'b0;
            state      <= S_DONE;
          end else if (iter_last) begin
            out_lo  <= lo_nxt;
            out_hi  <= hi_nxt;
            carry_q <= (op_q == OP_MUL) && (hi_nxt != '0);
            zero_q  <= (lo_nxt == '0);
            state   <= S_DONE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.outbus    = out_lo;
  assign bus.outbus_hi = out_hi;
  assign bus.carry     = carry_q;
  assign bus.overflow  = overflow_q;
  assign bus.zero      = zero_q;
  assign bus.div_zero  = div_zero_q;
  assign bus.done      = (state == S_DONE);
  assign bus.busy      = (state == S_EXEC_AS) || (state == S_ITER);
  assign bus.fsm_state = state;

endmodule
